spi_sample_engine: RTL and testbench

- Parametrised SPI master for the pedal datapath; generalises the fixed 16-bit, 4-trim SPI controller.
- On every adc_clock sample strobe it runs one full-duplex codec frame: it sends the DAC word and captures the ADC word.
- It then runs one trim-pot frame that reads one of N_TRIMS channels, round-robin.
- Outputs feed the compression, memory and control blocks; an overrun flag reports strobes that arrive while a transfer is still in progress.

---
 rtl/spi_sample_engine_if.sv | 36 +++
 rtl/spi_sample_engine.sv | 205 ++++++++++++++++++++
 tb/tb_spi_sample_engine.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sample_engine_if.sv
// Pin and result bundle of the pedal SPI sample engine.
// The engine is the master side; the bench and downstream logic use the slave side.
interface spi_sample_engine_if #(
   parameter int DATA_W  = 16,
   parameter int TRIM_W  = 8,
   parameter int N_TRIMS = 4,
   parameter int ADDR_W  = 2
);
   logic                      adc_clock;
   logic [DATA_W-1:0]         dac;
   logic                      clr_overrun;
   logic                      miso;
   logic                      mosi;
   logic                      sclk;
   logic                      cs_codec_n;
   logic                      cs_trim_n;
   logic [DATA_W-1:0]         adc;
   logic                      adc_valid;
   logic [N_TRIMS*TRIM_W-1:0] trim;
   logic                      trim_valid;
   logic [ADDR_W-1:0]         trim_idx;
   logic                      busy;
   logic                      overrun;

   modport master (
      input  adc_clock, dac, clr_overrun, miso,
      output mosi, sclk, cs_codec_n, cs_trim_n, adc, adc_valid,
             trim, trim_valid, trim_idx, busy, overrun
   );

   modport slave (
      output adc_clock, dac, clr_overrun, miso,
      input  mosi, sclk, cs_codec_n, cs_trim_n, adc, adc_valid,
             trim, trim_valid, trim_idx, busy, overrun
   );
endinterface

// File: rtl/spi_sample_engine.sv
// SPI master for the pedal datapath: one codec frame followed by one round-robin
// trim-pot frame per adc_clock strobe, SPI mode 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for an adc_clock rising edge, all chip selects high
// CS_SETUP | active cs low, sclk low, mosi holds the first bit
// SHIFT_HI | sclk high, miso sampled on entry
// SHIFT_LO | sclk low, mosi advanced on entry
// CS_HOLD  | sclk low after the last bit, cs still low
// GAP      | both cs high; result already written on entry
module spi_sample_engine #(
   parameter int DATA_W   = 16,
   parameter int TRIM_W   = 8,
   parameter int N_TRIMS  = 4,
   parameter int ADDR_W   = 2,
   parameter int HALF_DIV = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   spi_sample_engine_if.master bus
);

   localparam int TRIM_BITS = ADDR_W + TRIM_W;
   localparam int FRAME_W   = (DATA_W > TRIM_BITS) ? DATA_W : TRIM_BITS;
   localparam int TMR_W     = $clog2(HALF_DIV);
   localparam int BIT_W     = $clog2(FRAME_W);

   localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(HALF_DIV - 1);
   localparam logic [BIT_W-1:0] CODEC_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] TRIM_LAST  = BIT_W'(TRIM_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT_HI,
      SHIFT_LO,
      CS_HOLD,
      GAP
   } state_t;

   state_t                    state;
   logic [TMR_W-1:0]          tmr;
   logic [BIT_W-1:0]          bit_cnt;
   logic                      trim_frame;
   logic [FRAME_W-1:0]        tx;
   logic [FRAME_W-1:0]        rx;
   logic                      adc_clock_q;

   logic                      sclk_q;
   logic                      mosi_q;
   logic                      cs_codec_q;
   logic                      cs_trim_q;
   logic [DATA_W-1:0]         adc_q;
   logic                      adc_valid_q;
   logic [N_TRIMS*TRIM_W-1:0] trim_q;
   logic                      trim_valid_q;
   logic [ADDR_W-1:0]         trim_idx_q;
   logic                      busy_q;
   logic                      overrun_q;

   logic                      strobe;

   assign strobe = bus.adc_clock & ~adc_clock_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         tmr          <= '0;
         bit_cnt      <= '0;
         trim_frame   <= 1'b0;
         tx           <= '0;
         rx           <= '0;
         adc_clock_q  <= 1'b0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         cs_codec_q   <= 1'b1;
         cs_trim_q    <= 1'b1;
         adc_q        <= '0;
         adc_valid_q  <= 1'b0;
         trim_q       <= '0;
         trim_valid_q <= 1'b0;
         trim_idx_q   <= '0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         adc_clock_q  <= bus.adc_clock;
         adc_valid_q  <= 1'b0;
         trim_valid_q <= 1'b0;

         // A new overrun outranks a simultaneous clear.
         if (strobe && busy_q)
            overrun_q <= 1'b1;
         else if (bus.clr_overrun)
            overrun_q <= 1'b0;

         if (state != IDLE) begin
            if (tmr != '0)
               tmr <= tmr - 1'b1;
            else
               tmr <= TMR_LOAD;
         end

         unique case (state)
            IDLE: begin
               if (strobe) begin
                  busy_q     <= 1'b1;
                  trim_frame <= 1'b0;
                  tx         <= FRAME_W'(bus.dac) << (FRAME_W - DATA_W);
                  mosi_q     <= bus.dac[DATA_W-1];
                  cs_codec_q <= 1'b0;
                  bit_cnt    <= CODEC_LAST;
                  tmr        <= TMR_LOAD;
                  state      <= CS_SETUP;
               end
            end

            CS_SETUP: begin
               if (tmr == '0) begin
                  sclk_q <= 1'b1;
                  rx     <= {rx[FRAME_W-2:0], bus.miso};
                  state  <= SHIFT_HI;
               end
            end

            SHIFT_HI: begin
               if (tmr == '0) begin
                  sclk_q <= 1'b0;
                  tx     <= {tx[FRAME_W-2:0], 1'b0};
                  mosi_q <= tx[FRAME_W-2];
                  state  <= SHIFT_LO;
               end
            end

            SHIFT_LO: begin
               if (tmr == '0) begin
                  if (bit_cnt == '0) begin
                     state <= CS_HOLD;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                     sclk_q  <= 1'b1;
                     rx      <= {rx[FRAME_W-2:0], bus.miso};
                     state   <= SHIFT_HI;
                  end
               end
            end

            CS_HOLD: begin
               if (tmr == '0) begin
                  cs_codec_q <= 1'b1;
                  cs_trim_q  <= 1'b1;
                  mosi_q     <= 1'b0;
                  state      <= GAP;
                  if (!trim_frame) begin
                     adc_q       <= rx[DATA_W-1:0];
                     adc_valid_q <= 1'b1;
                  end else begin
                     // Address-phase bits have already shifted out of the low TRIM_W.
                     for (int k = 0; k < N_TRIMS; k++) begin
                        if (trim_idx_q == ADDR_W'(k))
                           trim_q[k*TRIM_W +: TRIM_W] <= rx[TRIM_W-1:0];
                     end
                     trim_valid_q <= 1'b1;
                     if (trim_idx_q == ADDR_W'(N_TRIMS - 1))
                        trim_idx_q <= '0;
                     else
                        trim_idx_q <= trim_idx_q + 1'b1;
                  end
               end
            end

            GAP: begin
               if (tmr == '0) begin
                  if (!trim_frame) begin
                     trim_frame <= 1'b1;
                     tx         <= FRAME_W'(trim_idx_q) << (FRAME_W - ADDR_W);
                     mosi_q     <= trim_idx_q[ADDR_W-1];
                     cs_trim_q  <= 1'b0;
                     bit_cnt    <= TRIM_LAST;
                     state      <= CS_SETUP;
                  end else begin
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sclk       = sclk_q;
   assign bus.mosi       = mosi_q;
   assign bus.cs_codec_n = cs_codec_q;
   assign bus.cs_trim_n  = cs_trim_q;
   assign bus.adc        = adc_q;
   assign bus.adc_valid  = adc_valid_q;
   assign bus.trim       = trim_q;
   assign bus.trim_valid = trim_valid_q;
   assign bus.trim_idx   = trim_idx_q;
   assign bus.busy       = busy_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_spi_sample_engine.sv
// Scoreboard bench for spi_sample_engine: default instance plus a 24-bit/3-trim instance,
// each with a mode-0 codec/trim slave model and a monitor that checks every result strobe.
module tb_spi_sample_engine;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   spi_sample_engine_if #(.DATA_W(16), .TRIM_W(8), .N_TRIMS(4), .ADDR_W(2)) b0 ();
   spi_sample_engine_if #(.DATA_W(24), .TRIM_W(8), .N_TRIMS(3), .ADDR_W(2)) b1 ();

   spi_sample_engine #(.DATA_W(16), .TRIM_W(8), .N_TRIMS(4), .ADDR_W(2), .HALF_DIV(4)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(b0.master));
   spi_sample_engine #(.DATA_W(24), .TRIM_W(8), .N_TRIMS(3), .ADDR_W(2), .HALF_DIV(2)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(b1.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int id; logic [31:0] val; } word_exp_t;
   typedef struct { int id; int idx; logic [7:0] val; } trim_exp_t;
   word_exp_t exp_tx_q[$];
   word_exp_t exp_adc_q[$];
   trim_exp_t exp_trim_q[$];

   logic        p_sclk[2], p_csc[2], p_cst[2], p_busy[2];
   int          nfall[2], nrise[2], clow[2];
   int          brise[2], tfall[2];
   int          nframes[2] = '{0, 0};
   logic [31:0] rxw[2];
   logic [1:0]  addr_rx[2];
   bit          tmode[2];
   logic [31:0] codec_resp[2];
   int          idx_m[2] = '{0, 0};
   int          excl_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event with no expectation queued", name);
   endtask

   // Slave model + monitor, evaluated 1 time unit after every rising clk edge.
   task automatic observe(input int id, input logic rst, sclk, csc, cst, mosi, busy, av,
                          input logic [31:0] adc, input logic tv, input logic [63:0] trim,
                          input logic [31:0] tidx, output logic miso);
      int dw, hd, nt, bp;
      logic [31:0] resp, mask;
      word_exp_t we;
      trim_exp_t te;
      dw   = (id == 0) ? 16 : 24;
      hd   = (id == 0) ? 4 : 2;
      nt   = (id == 0) ? 4 : 3;
      mask = (32'h1 << dw) - 32'h1;
      miso = 1'b0;
      if (!rst) begin
         brise[id] = -1;
         tfall[id] = -1;
         tmode[id] = 1'b0;
         nfall[id] = 0;
      end else begin
         if (!csc && !cst) excl_bad++;
         if (sclk && csc && cst) excl_bad++;
         if (!p_busy[id] && busy) begin
            brise[id] = cyc;
            nframes[id]++;
         end
         if (p_busy[id] && !busy && brise[id] >= 0 && tfall[id] >= 0) begin
            chk("codec_frame_len", 64'(tfall[id] - brise[id]), 64'((2*dw + 3)*hd));
            chk("trim_frame_len", 64'(cyc - tfall[id]), 64'((2*10 + 3)*hd));
            chk("busy_len", 64'(cyc - brise[id]), 64'((2*dw + 3)*hd + 23*hd));
         end
         if (p_csc[id] && !csc) begin
            nfall[id] = 0; nrise[id] = 0; rxw[id] = 0; clow[id] = 0; tmode[id] = 1'b0;
         end
         if (p_cst[id] && !cst) begin
            nfall[id] = 0; nrise[id] = 0; rxw[id] = 0; clow[id] = 0; tmode[id] = 1'b1;
            tfall[id] = cyc;
         end
         if (!csc || !cst) clow[id]++;
         if (!p_sclk[id] && sclk) begin
            rxw[id] = {rxw[id][30:0], mosi};
            nrise[id]++;
            if (tmode[id] && nrise[id] == 2) addr_rx[id] = rxw[id][1:0];
         end
         if (p_sclk[id] && !sclk) nfall[id]++;
         if (!p_csc[id] && csc) begin
            chk("codec_cs_low_len", 64'(clow[id]), 64'((2*dw + 2)*hd));
            if (exp_tx_q.size() == 0) fail_now("codec_frame_unexpected");
            else begin
               we = exp_tx_q.pop_front();
               chk("codec_mosi_word", 64'(rxw[id] & mask), 64'(we.val & mask));
            end
         end
         if (!p_cst[id] && cst) begin
            chk("trim_cs_low_len", 64'(clow[id]), 64'((2*10 + 2)*hd));
            if (exp_trim_q.size() == 0) fail_now("trim_frame_unexpected");
            else chk("trim_mosi_addr", 64'(rxw[id][9:0]), 64'({exp_trim_q[0].idx[1:0], 8'h00}));
         end
         if (av) begin
            if (exp_adc_q.size() == 0) fail_now("adc_valid_unexpected");
            else begin
               we = exp_adc_q.pop_front();
               chk("adc_value", 64'(adc), 64'(we.val & mask));
               chk("adc_valid_latency", 64'(cyc - brise[id]), 64'((2*dw + 2)*hd));
            end
         end
         if (tv) begin
            if (exp_trim_q.size() == 0) fail_now("trim_valid_unexpected");
            else begin
               te = exp_trim_q.pop_front();
               chk("trim_value", (trim >> (te.idx*8)) & 64'hFF, 64'(te.val));
               chk("trim_idx_next", 64'(tidx), 64'((te.idx + 1) % nt));
            end
         end
         if (!csc || !cst) begin
            if (!tmode[id]) begin
               resp = codec_resp[id];
               bp   = dw - 1 - nfall[id];
               if (bp >= 0 && bp < dw) miso = resp[bp];
            end else if (nfall[id] < 2) begin
               miso = 1'b1;
            end else begin
               resp = 32'(8'h10 + 8'(addr_rx[id]));
               bp   = 9 - nfall[id];
               if (bp >= 0 && bp < 8) miso = resp[bp];
            end
         end
      end
      p_sclk[id] = sclk;
      p_csc[id]  = csc;
      p_cst[id]  = cst;
      p_busy[id] = busy;
   endtask

   initial begin
      logic m;
      b0.miso = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         observe(0, rst_n, b0.sclk, b0.cs_codec_n, b0.cs_trim_n, b0.mosi, b0.busy, b0.adc_valid,
                 32'(b0.adc), b0.trim_valid, 64'(b0.trim), 32'(b0.trim_idx), m);
         b0.miso = m;
      end
   end

   initial begin
      logic m;
      b1.miso = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         observe(1, rst_n, b1.sclk, b1.cs_codec_n, b1.cs_trim_n, b1.mosi, b1.busy, b1.adc_valid,
                 32'(b1.adc), b1.trim_valid, 64'(b1.trim), 32'(b1.trim_idx), m);
         b1.miso = m;
      end
   end

   task automatic frame(input int id, input logic [31:0] dac, input logic [31:0] resp,
                        input bit expect_result);
      word_exp_t we;
      trim_exp_t te;
      int nt;
      nt = (id == 0) ? 4 : 3;
      codec_resp[id] = resp;
      if (expect_result) begin
         we.id = id; we.val = dac;  exp_tx_q.push_back(we);
         we.val = resp;             exp_adc_q.push_back(we);
         te.id = id; te.idx = idx_m[id]; te.val = 8'(8'h10 + idx_m[id]);
         exp_trim_q.push_back(te);
         idx_m[id] = (idx_m[id] + 1) % nt;
      end
      @(negedge clk);
      if (id == 0) begin b0.dac = dac[15:0]; b0.adc_clock = 1'b1; end
      else         begin b1.dac = dac[23:0]; b1.adc_clock = 1'b1; end
      @(negedge clk);
      // Only the value at acceptance may be transmitted.
      if (id == 0) begin b0.dac = ~dac[15:0]; b0.adc_clock = 1'b0; end
      else         begin b1.dac = ~dac[23:0]; b1.adc_clock = 1'b0; end
   endtask

   task automatic wait_idle(input int id, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (((id == 0) ? b0.busy : b1.busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ((id == 0) ? b0.busy : b1.busy) begin
         errors++;
         $display("FAIL wait_idle dut%0d: busy got 1, want 0 within %0d clks", id, budget);
      end
   endtask

   initial begin
      int viol;
      int n0;
      rst_n = 1'b0;
      b0.adc_clock = 1'b0; b0.dac = '0; b0.clr_overrun = 1'b0;
      b1.adc_clock = 1'b0; b1.dac = '0; b1.clr_overrun = 1'b0;

      // Reset values, then a quiet idle period.
      repeat (5) @(negedge clk);
      chk("rst_sclk", 64'(b0.sclk), 0);
      chk("rst_mosi", 64'(b0.mosi), 0);
      chk("rst_cs_codec_n", 64'(b0.cs_codec_n), 1);
      chk("rst_cs_trim_n", 64'(b0.cs_trim_n), 1);
      chk("rst_adc", 64'(b0.adc), 0);
      chk("rst_trim", 64'(b0.trim), 0);
      chk("rst_valids", 64'({b0.adc_valid, b0.trim_valid}), 0);
      chk("rst_trim_idx", 64'(b0.trim_idx), 0);
      chk("rst_busy_overrun", 64'({b0.busy, b0.overrun}), 0);
      rst_n = 1'b1;
      viol = 0;
      repeat (500) begin
         @(negedge clk);
         if (b0.sclk !== 1'b0 || b0.cs_codec_n !== 1'b1 || b0.cs_trim_n !== 1'b1 || b0.busy !== 1'b0)
            viol++;
      end
      chk("idle_static", 64'(viol), 0);

      // Codec loopback and trim round-robin: addresses 0,1,2,3,0.
      frame(0, 32'h1234, 32'hA5C3, 1'b1);
      wait_idle(0, 300);
      chk("loopback_adc", 64'(b0.adc), 64'h A5C3);
      repeat (60) @(negedge clk);
      frame(0, 32'h8001, 32'h5AA5, 1'b1); wait_idle(0, 300); repeat (60) @(negedge clk);
      frame(0, 32'h00FF, 32'hFF00, 1'b1); wait_idle(0, 300); repeat (60) @(negedge clk);
      frame(0, 32'hC3C3, 32'h0001, 1'b1); wait_idle(0, 300); repeat (60) @(negedge clk);
      frame(0, 32'h7FFE, 32'h8000, 1'b1); wait_idle(0, 300); repeat (60) @(negedge clk);
      chk("trim_after_5", 64'(b0.trim), 64'h1312_1110);
      chk("trim_idx_after_5", 64'(b0.trim_idx), 1);

      // Overrun: second strobe 100 clks into the transfer.
      n0 = nframes[0];
      frame(0, 32'h0F0F, 32'h5A5A, 1'b1);
      repeat (100) @(negedge clk);
      b0.adc_clock = 1'b1;
      @(negedge clk);
      b0.adc_clock = 1'b0;
      chk("overrun_set", 64'(b0.overrun), 1);
      wait_idle(0, 300);
      repeat (300) @(negedge clk);
      chk("overrun_no_extra_frame", 64'(nframes[0] - n0), 1);
      chk("overrun_sticky", 64'(b0.overrun), 1);
      b0.clr_overrun = 1'b1;
      @(negedge clk);
      b0.clr_overrun = 1'b0;
      chk("overrun_cleared", 64'(b0.overrun), 0);
      frame(0, 32'h3C3C, 32'h0101, 1'b1);
      repeat (50) @(negedge clk);
      b0.adc_clock = 1'b1;
      b0.clr_overrun = 1'b1;
      @(negedge clk);
      b0.adc_clock = 1'b0;
      b0.clr_overrun = 1'b0;
      chk("overrun_set_beats_clear", 64'(b0.overrun), 1);
      wait_idle(0, 300);
      repeat (20) @(negedge clk);

      // Reset during bit 7 of a codec frame.
      frame(0, 32'hBEEF, 32'h7777, 1'b0);
      repeat (62) @(negedge clk);
      chk("midframe_pre_cs", 64'({b0.cs_codec_n, b0.sclk}), 64'b01);
      rst_n = 1'b0;
      #1;
      chk("midframe_async_cs_sclk", 64'({b0.cs_codec_n, b0.sclk}), 64'b10);
      chk("midframe_adc", 64'(b0.adc), 0);
      chk("midframe_busy_overrun", 64'({b0.busy, b0.overrun}), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idx_m[0] = 0;
      idx_m[1] = 0;
      repeat (200) @(negedge clk);
      chk("midframe_adc_after", 64'(b0.adc), 0);
      frame(0, 32'hC001, 32'h1357, 1'b1);
      wait_idle(0, 300);
      chk("post_reset_adc", 64'(b0.adc), 64'h1357);
      chk("post_reset_trim_idx", 64'(b0.trim_idx), 1);

      // Wider codec word, faster sclk, three trim channels.
      frame(1, 32'hABCDEF, 32'h123456, 1'b1); wait_idle(1, 200); repeat (20) @(negedge clk);
      frame(1, 32'h800001, 32'hF0F0F0, 1'b1); wait_idle(1, 200); repeat (20) @(negedge clk);
      chk("sweep_trim_idx_2", 64'(b1.trim_idx), 2);
      frame(1, 32'h00FFFF, 32'h000001, 1'b1); wait_idle(1, 200); repeat (20) @(negedge clk);
      chk("sweep_trim_idx_wrap", 64'(b1.trim_idx), 0);
      frame(1, 32'h5A5A5A, 32'hA5A5A5, 1'b1); wait_idle(1, 200); repeat (20) @(negedge clk);
      chk("sweep_trim", 64'(b1.trim), 64'h12_11_10);
      chk("sweep_adc", 64'(b1.adc), 64'hA5A5A5);

      chk("cs_exclusive_sclk_gated", 64'(excl_bad), 0);
      chk("sb_tx_empty", 64'(exp_tx_q.size()), 0);
      chk("sb_adc_empty", 64'(exp_adc_q.size()), 0);
      chk("sb_trim_empty", 64'(exp_trim_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
